// File: rtl/alu_seq_pkg.sv
// Shared definitions for the registered ALU: op codes, status flag positions, FSM states.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_ADC = 3'd2,
    ALU_SBC = 3'd3,
    ALU_AND = 3'd4,
    ALU_OR  = 3'd5,
    ALU_XOR = 3'd6,
    ALU_MUL = 3'd7
  } alu_op_e;

  // Bit positions inside the ---SVNZC status byte
  localparam int unsigned CF = 0;
  localparam int unsigned ZF = 1;
  localparam int unsigned NF = 2;
  localparam int unsigned VF = 3;
  localparam int unsigned SF = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  // Assemble a status byte; the upper three bits pass through from the caller
  function automatic logic [7:0] pack_status(input logic [2:0] top, input logic s,
                                             input logic v, input logic n,
                                             input logic z, input logic c);
    logic [7:0] st;
    st     = {top, 5'b0};
    st[SF] = s;
    st[VF] = v;
    st[NF] = n;
    st[ZF] = z;
    st[CF] = c;
    return st;
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Shift-add unsigned multiplier datapath: one partial-product step per cycle.
module alu_seq_mul #(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = $clog2(W + 1)
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic         step_i,
  input  logic [W-1:0] mcand_i,
  input  logic [W-1:0] mplier_i,
  output logic [W-1:0] nxt_hi_c,
  output logic [W-1:0] nxt_lo_c,
  output logic         last_c
);

  logic [W-1:0]  mcand_q, mcand_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0]    sum_c;

  // One step: conditional add into the high half, then shift {carry,hi,lo} right
  always_comb begin
    sum_c    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    nxt_hi_c = sum_c[W:1];
    nxt_lo_c = {sum_c[0], lo_q[W-1:1]};
    last_c   = (cnt_q == CW'(1));
  end

  // Next-state selection for load versus step
  always_comb begin
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      mcand_d = mcand_i;
      hi_d    = '0;
      lo_d    = mplier_i;
      cnt_d   = CW'(W);
    end else if (step_i && (cnt_q != '0)) begin
      hi_d  = nxt_hi_c;
      lo_d  = nxt_lo_c;
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with carry-chained arithmetic, logic ops and a multi-cycle multiply.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter  int unsigned W  = 8,
  localparam int unsigned CW = $clog2(W + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [7:0]   st_in,
  output logic [W-1:0] r,
  output logic [W-1:0] r_hi,
  output logic [7:0]   st_out,
  output logic         busy,
  output logic         done
);

  state_e       state_q;
  logic [W-1:0] r_q, r_hi_q;
  logic [7:0]   st_q;
  logic         busy_q, done_q;
  logic [2:0]   st_top_q;

  alu_op_e      op_c;
  logic         cin_c, c_c, v_c, n_c, z_c;
  logic [W:0]   sum_c, dif_c;
  logic [W-1:0] res_c;
  logic [7:0]   st_c, mul_st_c;
  logic         mul_load_c, mul_step_c, mul_last_c;
  logic [W-1:0] mul_hi_c, mul_lo_c;

  assign mul_load_c = (state_q == ST_IDLE) && start && (op_c == ALU_MUL);
  assign mul_step_c = (state_q == ST_MUL);

  alu_seq_mul #(.W(W), .CW(CW)) u_mul (
    .clk_i    (clk),
    .reset_i  (reset),
    .load_i   (mul_load_c),
    .step_i   (mul_step_c),
    .mcand_i  (a),
    .mplier_i (b),
    .nxt_hi_c (mul_hi_c),
    .nxt_lo_c (mul_lo_c),
    .last_c   (mul_last_c)
  );

  // Single-cycle result and flags for every op except MUL
  always_comb begin
    op_c  = alu_op_e'(op);
    cin_c = ((op_c == ALU_ADC) || (op_c == ALU_SBC)) ? st_in[CF] : 1'b0;
    sum_c = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin_c};
    dif_c = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin_c};
    res_c = '0;
    c_c   = st_in[CF];
    v_c   = 1'b0;
    case (op_c)
      ALU_ADD, ALU_ADC: begin
        res_c = sum_c[W-1:0];
        c_c   = sum_c[W];
        v_c   = (a[W-1] == b[W-1]) && (res_c[W-1] != a[W-1]);
      end
      ALU_SUB, ALU_SBC: begin
        res_c = dif_c[W-1:0];
        c_c   = dif_c[W];
        v_c   = (a[W-1] != b[W-1]) && (res_c[W-1] != a[W-1]);
      end
      ALU_AND: res_c = a & b;
      ALU_OR:  res_c = a | b;
      ALU_XOR: res_c = a ^ b;
      default: res_c = '0;
    endcase
    n_c      = res_c[W-1];
    z_c      = ~|res_c;
    st_c     = pack_status(st_in[7:5], v_c ^ n_c, v_c, n_c, z_c, c_c);
    mul_st_c = pack_status(st_top_q, mul_hi_c[W-1], 1'b0, mul_hi_c[W-1],
                           ~|{mul_hi_c, mul_lo_c}, |mul_hi_c);
  end

  // Control FSM and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      r_q      <= '0;
      r_hi_q   <= '0;
      st_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      st_top_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (op_c == ALU_MUL) begin
              state_q  <= ST_MUL;
              busy_q   <= 1'b1;
              st_top_q <= st_in[7:5];
            end else begin
              r_q    <= res_c;
              r_hi_q <= '0;
              st_q   <= st_c;
              done_q <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (mul_last_c) begin
            r_q     <= mul_lo_c;
            r_hi_q  <= mul_hi_c;
            st_q    <= mul_st_c;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign r      = r_q;
  assign r_hi   = r_hi_q;
  assign st_out = st_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed bench for alu_seq against an integer-arithmetic reference model.
module tb_alu_seq;

  localparam int unsigned W = 8;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [7:0]   st_in = '0;
  logic [W-1:0] r, r_hi;
  logic [7:0]   st_out;
  logic         busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int r;
    int r_hi;
    int st;
  } exp_t;

  exp_t last_exp;

  alu_seq #(.W(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .st_in  (st_in),
    .r      (r),
    .r_hi   (r_hi),
    .st_out (st_out),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int to_signed(input int x);
    return (x >= M / 2) ? x - M : x;
  endfunction

  // Reference: plain integer arithmetic following the op definitions
  function automatic exp_t model(input int opc, input int ai, input int bi, input int st);
    exp_t e;
    int cin, s, sv, c, v, n, z, sf;
    longint p;
    cin = st & 1;
    c = 0; v = 0; e.r_hi = 0;
    case (opc)
      0, 2: begin
        s   = ai + bi + ((opc == 2) ? cin : 0);
        sv  = to_signed(ai) + to_signed(bi) + ((opc == 2) ? cin : 0);
        e.r = s % M;
        c   = (s >= M) ? 1 : 0;
        v   = (sv > M / 2 - 1 || sv < -(M / 2)) ? 1 : 0;
      end
      1, 3: begin
        s   = ai - bi - ((opc == 3) ? cin : 0);
        sv  = to_signed(ai) - to_signed(bi) - ((opc == 3) ? cin : 0);
        e.r = (s + 2 * M) % M;
        c   = (ai < bi + ((opc == 3) ? cin : 0)) ? 1 : 0;
        v   = (sv > M / 2 - 1 || sv < -(M / 2)) ? 1 : 0;
      end
      4: begin e.r = ai & bi; c = cin; end
      5: begin e.r = ai | bi; c = cin; end
      6: begin e.r = ai ^ bi; c = cin; end
      default: begin
        p      = longint'(ai) * longint'(bi);
        e.r    = int'(p % M);
        e.r_hi = int'(p / M);
        c      = (e.r_hi != 0) ? 1 : 0;
      end
    endcase
    if (opc == 7) begin
      n = (e.r_hi >= M / 2) ? 1 : 0;
      z = (e.r == 0 && e.r_hi == 0) ? 1 : 0;
    end else begin
      n = (e.r >= M / 2) ? 1 : 0;
      z = (e.r == 0) ? 1 : 0;
    end
    sf = v ^ n;
    e.st = (st & 'hE0) | (sf << 4) | (v << 3) | (n << 2) | (z << 1) | c;
    return e;
  endfunction

  task automatic check_result(input string tag, input exp_t e);
    check({tag, "_r"}, longint'(r), longint'(e.r));
    check({tag, "_rhi"}, longint'(r_hi), longint'(e.r_hi));
    check({tag, "_st"}, longint'(st_out), longint'(e.st));
  endtask

  // Drive one start pulse; returns after the sampling edge (+1)
  task automatic pulse(input int opc, input int ai, input int bi, input int st);
    start = 1'b1;
    op    = 3'(opc);
    a     = W'(ai);
    b     = W'(bi);
    st_in = 8'(st);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic single_op(input string tag, input int opc, input int ai, input int bi,
                           input int st);
    exp_t e;
    e = model(opc, ai, bi, st);
    pulse(opc, ai, bi, st);
    check({tag, "_done"}, longint'(done), 1);
    check_result(tag, e);
    last_exp = e;
  endtask

  // MUL with optional stray start injected in cycle inj (0 = none)
  task automatic mul_op(input string tag, input int ai, input int bi, input int st,
                        input int inj);
    exp_t e;
    int k, bad_busy;
    e = model(7, ai, bi, st);
    pulse(7, ai, bi, st);
    k = 1;
    bad_busy = 0;
    while (!done && k < int'(W) + 4) begin
      if (!busy) bad_busy++;
      if (k == inj) begin
        start = 1'b1; op = 3'd0; a = W'(8'h11); b = W'(8'h22);
      end
      @(posedge clk); #1;
      start = 1'b0;
      k++;
    end
    check({tag, "_latency"}, longint'(k), longint'(W + 1));
    check({tag, "_busy_during"}, longint'(bad_busy), 0);
    check({tag, "_busy_after"}, longint'(busy), 0);
    check_result(tag, e);
    last_exp = e;
    @(posedge clk); #1;
    check({tag, "_single_done"}, longint'(done), 0);
    check_result({tag, "_hold"}, e);
  endtask

  initial begin
    exp_t e0, e1;
    int opc, ai, bi, st, rnd_done;

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_r", longint'(r), 0);
    check("rst_rhi", longint'(r_hi), 0);
    check("rst_st", longint'(st_out), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    @(posedge clk); #1;
    check("idle_done", longint'(done), 0);

    single_op("add_ovf", 0, 'h7F, 'h01, 0);

    // SUB then SBC back-to-back, carry chained through the status byte
    e0 = model(1, 'h00, 'h01, 0);
    single_op("sub", 1, 'h00, 'h01, 0);
    e1 = model(3, 'h10, 'h00, e0.st);
    single_op("sbc", 3, 'h10, 'h00, e0.st);
    check("sbc_r_const", longint'(r), longint'(8'h0F));

    mul_op("mul_ff", 'hFF, 'hFF, 'hA0, 0);
    mul_op("mul_zero_inj", 'h00, 'h5A, 0, 3);

    // Reset in cycle 4 of a multiply aborts it
    pulse(7, 'hC3, 'h77, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", longint'(busy), 0);
    check("abort_done", longint'(done), 0);
    check("abort_r", longint'(r), 0);
    check("abort_rhi", longint'(r_hi), 0);
    check("abort_st", longint'(st_out), 0);
    single_op("post_rst_add", 0, 'h12, 'h34, 'hE1);
    rnd_done = 0;
    repeat (int'(W) + 2) begin
      @(posedge clk); #1;
      if (done) rnd_done++;
    end
    check("abort_no_late_done", longint'(rnd_done), 0);

    // Randomized sequence, occasional idle cycles checking that outputs hold
    for (int i = 0; i < 300; i++) begin
      opc = int'($urandom_range(0, 7));
      ai  = int'($urandom_range(0, M - 1));
      bi  = int'($urandom_range(0, M - 1));
      st  = int'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) ai = (M / 2) - 1;
      if ($urandom_range(0, 9) == 0) bi = 0;
      if (opc == 7) mul_op("rnd_mul", ai, bi, st, int'($urandom_range(0, 9)));
      else          single_op("rnd", opc, ai, bi, st);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        check("rnd_idle_done", longint'(done), 0);
        check_result("rnd_idle_hold", last_exp);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
